// File: rtl/simmem_ram_arbiter.sv
// Arbiter sharing one single-port RAM bank between the RAM_IN (enqueue) and
// RAM_OUT (dequeue) sides of the simmem linked-list buffer.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | round-robin between requesters, rr_q holds priority port
//   LOCKED_IN  | RAM_IN owns the bank for a read-modify-write, RAM_OUT held off
//   LOCKED_OUT | RAM_OUT owns the bank for a read-modify-write, RAM_IN held off
//
// A lock is force-released after MaxLockCycles locked cycles without an
// unlocking grant, so a stalled owner cannot starve the other port.
module simmem_ram_arbiter #(
    parameter int DataWidth     = 9,
    parameter int NumEntries    = 16,
    parameter int AddrWidth     = $clog2(NumEntries),
    parameter int MaxLockCycles = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [1:0]                        req_i,
    input  logic [1:0]                        we_i,
    input  logic [1:0]                        lock_i,
    input  logic [1:0][AddrWidth-1:0]         addr_i,
    input  logic [1:0][DataWidth-1:0]         wdata_i,
    output logic [1:0]                        gnt_o,
    output logic [1:0]                        rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              lock_timeout_o,
    output logic                              ram_req_o,
    output logic                              ram_we_o,
    output logic [AddrWidth-1:0]              ram_addr_o,
    output logic [DataWidth-1:0]              ram_wdata_o,
    input  logic [DataWidth-1:0]              ram_rdata_i
);

    typedef enum logic {RAM_IN = 1'b0, RAM_OUT = 1'b1} ram_port_e;
    typedef enum logic [1:0] {IDLE, LOCKED_IN, LOCKED_OUT} state_e;

    localparam logic [3:0] MaxCnt = 4'(MaxLockCycles);

    state_e     state_q, state_d;
    ram_port_e  rr_q, rr_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       rd_pend_q;
    ram_port_e  rd_port_q;

    logic       gnt_port;
    logic       owner;

    // Grant selection, lock tracking and next-state logic.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        lock_cnt_d     = lock_cnt_q;
        gnt_o          = 2'b00;
        lock_timeout_o = 1'b0;
        owner          = (state_q == LOCKED_OUT);

        case (state_q)
            IDLE: begin
                if (req_i == 2'b11) gnt_o[rr_q] = 1'b1;
                else                gnt_o       = req_i;
            end
            LOCKED_IN:  gnt_o[0] = req_i[0];
            LOCKED_OUT: gnt_o[1] = req_i[1];
            default:    gnt_o    = 2'b00;
        endcase

        // Hold the bank off while reset is asserted even if requests are up.
        if (!rst_ni) gnt_o = 2'b00;

        gnt_port = gnt_o[1];

        case (state_q)
            IDLE: begin
                if (|gnt_o) begin
                    rr_d = ram_port_e'(~gnt_port);
                    if (lock_i[gnt_port]) begin
                        state_d    = gnt_port ? LOCKED_OUT : LOCKED_IN;
                        lock_cnt_d = 4'd1;
                    end
                end
            end
            LOCKED_IN, LOCKED_OUT: begin
                if (gnt_o[owner] && !lock_i[owner]) begin
                    state_d    = IDLE;
                    lock_cnt_d = 4'd0;
                end else if (lock_cnt_q >= MaxCnt) begin
                    state_d        = IDLE;
                    lock_cnt_d     = 4'd0;
                    lock_timeout_o = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 4'd0;
            end
        endcase
    end

    // RAM strobe and payload muxed from the granted port; zeroed when idle.
    always_comb begin
        ram_req_o   = |gnt_o;
        ram_we_o    = ram_req_o & we_i[gnt_port];
        ram_addr_o  = ram_req_o ? addr_i[gnt_port]  : '0;
        ram_wdata_o = ram_req_o ? wdata_i[gnt_port] : '0;
    end

    // Arbitration state and outstanding-read bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= RAM_IN;
            lock_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= RAM_IN;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= ram_req_o & ~ram_we_o;
            rd_port_q  <= ram_port_e'(gnt_port);
        end
    end

    // Read data is a straight passthrough, steered by the registered port tag.
    always_comb begin
        rvalid_o = {rd_pend_q & rd_port_q, rd_pend_q & ~rd_port_q};
        rdata_o  = ram_rdata_i;
    end

endmodule

// File: tb/tb_simmem_ram_arbiter.sv
// Bench for simmem_ram_arbiter: directed stimulus with a read-response
// scoreboard drained by an independent monitor, plus a behavioural RAM bank.
module tb_simmem_ram_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req, we, lock;
    logic [1:0][3:0]  addr;
    logic [1:0][8:0]  wdata;
    logic [1:0]       gnt, rvalid;
    logic [8:0]       rdata;
    logic             lock_to;
    logic             ram_req, ram_we;
    logic [3:0]       ram_addr;
    logic [8:0]       ram_wdata;
    logic [8:0]       ram_rdata;

    logic [8:0]       mem [16];
    logic [9:0]       exp_q [$];   // {port, data}
    int               n_cmp = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    simmem_ram_arbiter #(
        .DataWidth(9), .NumEntries(16), .AddrWidth(4), .MaxLockCycles(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .lock_timeout_o(lock_to), .ram_req_o(ram_req),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    // Write-first single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest expected read response.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rvalid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {14'd0, rvalid}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_port", {14'd0, rvalid}, e[9] ? 16'd2 : 16'd1);
                chk("rdata", {7'd0, rdata}, {7'd0, e[8:0]});
            end
        end
    end

    // One arbitration cycle: drive, check grant/timeout, queue expected read.
    task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                        input logic [3:0] a_in, input logic [3:0] a_out,
                        input logic [8:0] wd_in, input logic [8:0] wd_out,
                        input logic [1:0] exp_gnt, input logic exp_to,
                        input logic [8:0] exp_rd);
        req = r; we = w; lock = l;
        addr[0] = a_in; addr[1] = a_out;
        wdata[0] = wd_in; wdata[1] = wd_out;
        @(negedge clk); #1;
        chk("gnt", {14'd0, gnt}, {14'd0, exp_gnt});
        chk("lock_timeout", {15'd0, lock_to}, {15'd0, exp_to});
        if (exp_gnt[0] && !w[0]) exp_q.push_back({1'b0, exp_rd});
        if (exp_gnt[1] && !w[1]) exp_q.push_back({1'b1, exp_rd});
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 9'h040 + 9'(i);
        ram_rdata = '0;
        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; lock = 2'b00;
        addr[0] = 4'd3; addr[1] = 4'd5; wdata = '0;

        // Reset held with both ports requesting: nothing granted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", {14'd0, gnt}, 16'd0);
        chk("reset_rvalid", {14'd0, rvalid}, 16'd0);
        chk("reset_timeout", {15'd0, lock_to}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Conflicting reads alternate starting with RAM_IN.
        step(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 9'h0, 9'h0, 2'b01, 1'b0, 9'h043);
        step(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 9'h0, 9'h0, 2'b10, 1'b0, 9'h045);
        step(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 9'h0, 9'h0, 2'b01, 1'b0, 9'h043);
        step(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 9'h0, 9'h0, 2'b10, 1'b0, 9'h045);

        // Locked read-modify-write by RAM_IN; RAM_OUT held off until unlock.
        step(2'b11, 2'b00, 2'b01, 4'd2, 4'd4, 9'h0,   9'h0, 2'b01, 1'b0, 9'h042);
        step(2'b10, 2'b00, 2'b00, 4'd2, 4'd4, 9'h0,   9'h0, 2'b00, 1'b0, 9'h0);
        step(2'b11, 2'b01, 2'b00, 4'd2, 4'd4, 9'h1F0, 9'h0, 2'b01, 1'b0, 9'h0);
        step(2'b10, 2'b00, 2'b00, 4'd2, 4'd2, 9'h0,   9'h0, 2'b10, 1'b0, 9'h1F0);

        // RAM_OUT locks then goes quiet: forced release on the 4th locked cycle.
        step(2'b10, 2'b00, 2'b10, 4'd6, 4'd4, 9'h0, 9'h0, 2'b10, 1'b0, 9'h044);
        step(2'b01, 2'b00, 2'b00, 4'd6, 4'd4, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);
        step(2'b01, 2'b00, 2'b00, 4'd6, 4'd4, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);
        step(2'b01, 2'b00, 2'b00, 4'd6, 4'd4, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);
        step(2'b01, 2'b00, 2'b00, 4'd6, 4'd4, 9'h0, 9'h0, 2'b00, 1'b1, 9'h0);
        step(2'b01, 2'b00, 2'b00, 4'd6, 4'd4, 9'h0, 9'h0, 2'b01, 1'b0, 9'h046);

        // Write then read back the same address from RAM_OUT.
        step(2'b10, 2'b10, 2'b00, 4'd0, 4'd7, 9'h0, 9'h1A5, 2'b10, 1'b0, 9'h0);
        step(2'b10, 2'b00, 2'b00, 4'd0, 4'd7, 9'h0, 9'h0,   2'b10, 1'b0, 9'h1A5);
        step(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 9'h0, 9'h0,   2'b00, 1'b0, 9'h0);

        // Read granted, then reset hits before the edge: response is dropped.
        req = 2'b01; we = 2'b00; lock = 2'b00; addr[0] = 4'd3;
        @(negedge clk); #1;
        chk("pre_reset_gnt", {14'd0, gnt}, 16'd1);
        rst_n = 1'b0;
        req = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_mid_rvalid", {14'd0, rvalid}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);
        // Priority must be back at RAM_IN after reset.
        step(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 9'h0, 9'h0, 2'b01, 1'b0, 9'h043);
        step(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);
        step(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 9'h0, 9'h0, 2'b00, 1'b0, 9'h0);

        chk("responses_outstanding", 16'(exp_q.size()), 16'd0);
        chk("ram_word_2", {7'd0, mem[2]}, 16'h01F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
